// File: rtl/mos_decoder.sv
// mos_decoder: instruction decoder and T-state sequencer for the MOSby
// 6502-style core. A single input clock is divided into two non-overlapping
// phase outputs; one machine cycle spans two clk periods. The sequencer walks
// FETCH -> T1 (-> T2) -> FETCH per instruction. All datapath strobes are
// decoded combinationally from the current state and the instruction register.
//
// Build option: define ILLEGAL_OP_HALT_EN so that an unlisted opcode parks the
// sequencer in HALT until reset. Without it, unlisted opcodes run as a
// two-cycle NOP.

module mos_decoder (
   input  logic       clk,
   input  logic       rst,
   input  logic       flush,
   input  logic       normal,
   input  logic [7:0] instruction,
   output logic       clk_1,
   output logic       clk_2,
   output logic       w_rd,
   output logic       pc_data,
   output logic       increment,
   output logic       lower_byte,
   output logic       x_con,
   output logic       y_con,
   output logic       accumulator_con,
   output logic       status_con,
   output logic       stack_pointer_con,
   output logic       branch_uncon,
   output logic       branch_con,
   output logic [3:0] alu_op,
   output logic [2:0] branch_op,
   output logic [1:0] operand_mux_con
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      T1    = 2'd1,
      T2    = 2'd2,
      HALT  = 2'd3
   } state_t;

   typedef enum logic [2:0] {
      CLS_IMPLIED = 3'd0,
      CLS_IMM     = 3'd1,
      CLS_BRANCH  = 3'd2,
      CLS_JMP     = 3'd3,
      CLS_ILLEGAL = 3'd4
   } op_class_t;

   localparam logic [3:0] ALU_ADD  = 4'h0;
   localparam logic [3:0] ALU_SUB  = 4'h1;
   localparam logic [3:0] ALU_AND  = 4'h2;
   localparam logic [3:0] ALU_OR   = 4'h3;
   localparam logic [3:0] ALU_EOR  = 4'h4;
   localparam logic [3:0] ALU_PASS = 4'h5;
   localparam logic [3:0] ALU_INC  = 4'h6;
   localparam logic [3:0] ALU_DEC  = 4'h7;
   localparam logic [3:0] ALU_CMP  = 4'h8;
   localparam logic [3:0] ALU_NOP  = 4'hF;

   localparam logic [1:0] MUX_DATA = 2'b00;
   localparam logic [1:0] MUX_X    = 2'b01;
   localparam logic [1:0] MUX_Y    = 2'b10;
   localparam logic [1:0] MUX_SP   = 2'b11;

   localparam logic [7:0] OP_NOP = 8'hEA;

   logic      ph;
   state_t    state;
   state_t    next_state;
   logic [7:0] ir;
   op_class_t op_class;
   logic      active;
   logic      flush_now;

   // Phase divider: ph flips on every clk edge, giving one machine cycle per two clks
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ph <= 1'b0;
      end else begin
         ph <= ~ph;
      end
   end

   assign clk_1 = rst & ~ph;
   assign clk_2 = rst & ph;

   // HALT is only left through reset, so flush is ignored there
   assign flush_now = flush && (state != HALT);

   // State register: advances only on the closing edge of a machine cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= FETCH;
      end else if (ph) begin
         if (flush_now) begin
            state <= FETCH;
         end else if (normal) begin
            state <= next_state;
         end
      end
   end

   // Instruction register: captures the opcode at the end of FETCH, NOP on flush
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ir <= OP_NOP;
      end else if (ph) begin
         if (flush_now) begin
            ir <= OP_NOP;
         end else if (normal && (state == FETCH)) begin
            ir <= instruction;
         end
      end
   end

   // Opcode classification used by both sequencing and strobe decode
   always_comb begin
      op_class = CLS_ILLEGAL;
      case (ir)
         8'hEA, 8'hAA, 8'hA8, 8'h8A, 8'h98, 8'hE8, 8'hC8,
         8'hCA, 8'h88, 8'h9A, 8'hBA, 8'h18, 8'h38:
            op_class = CLS_IMPLIED;
         8'h69, 8'hE9, 8'h29, 8'h09, 8'h49, 8'hA9, 8'hA2,
         8'hA0, 8'hC9, 8'hE0, 8'hC0:
            op_class = CLS_IMM;
         8'h10, 8'h30, 8'h50, 8'h70, 8'h90, 8'hB0, 8'hD0, 8'hF0:
            op_class = CLS_BRANCH;
         8'h4C:
            op_class = CLS_JMP;
         default:
            op_class = CLS_ILLEGAL;
      endcase
   end

   // Next-state logic: immediate and JMP take a second execute cycle
   always_comb begin
      next_state = state;
      case (state)
         FETCH: next_state = T1;
         T1: begin
            case (op_class)
               CLS_IMM, CLS_JMP: next_state = T2;
`ifdef ILLEGAL_OP_HALT_EN
               CLS_ILLEGAL:      next_state = HALT;
`endif
               default:          next_state = FETCH;
            endcase
         end
         T2: next_state = FETCH;
`ifdef ILLEGAL_OP_HALT_EN
         HALT: next_state = HALT;
`else
         HALT: next_state = FETCH;
`endif
         default: next_state = FETCH;
      endcase
   end

   assign active = rst & normal & ~flush;

   // Strobe decode from (state, IR); everything idles during reset, stall or flush
   always_comb begin
      w_rd              = 1'b0;
      pc_data           = 1'b0;
      increment         = 1'b0;
      lower_byte        = 1'b0;
      x_con             = 1'b0;
      y_con             = 1'b0;
      accumulator_con   = 1'b0;
      status_con        = 1'b0;
      stack_pointer_con = 1'b0;
      branch_uncon      = 1'b0;
      branch_con        = 1'b0;
      alu_op            = ALU_NOP;
      branch_op         = 3'b000;
      operand_mux_con   = MUX_DATA;
      if (active) begin
         case (state)
            FETCH: begin
               increment = 1'b1;
            end
            T1: begin
               case (op_class)
                  CLS_IMM: begin
                     increment = 1'b1;
                  end
                  CLS_BRANCH: begin
                     increment  = 1'b1;
                     branch_con = 1'b1;
                     branch_op  = ir[7:5];
                  end
                  CLS_JMP: begin
                     increment  = 1'b1;
                     lower_byte = 1'b1;
                  end
                  CLS_IMPLIED: begin
                     case (ir)
                        8'hAA: begin alu_op = ALU_PASS; x_con = 1'b1; end
                        8'hA8: begin alu_op = ALU_PASS; y_con = 1'b1; end
                        8'h8A: begin alu_op = ALU_PASS; operand_mux_con = MUX_X; accumulator_con = 1'b1; end
                        8'h98: begin alu_op = ALU_PASS; operand_mux_con = MUX_Y; accumulator_con = 1'b1; end
                        8'hE8: begin alu_op = ALU_INC; operand_mux_con = MUX_X; x_con = 1'b1; status_con = 1'b1; end
                        8'hC8: begin alu_op = ALU_INC; operand_mux_con = MUX_Y; y_con = 1'b1; status_con = 1'b1; end
                        8'hCA: begin alu_op = ALU_DEC; operand_mux_con = MUX_X; x_con = 1'b1; status_con = 1'b1; end
                        8'h88: begin alu_op = ALU_DEC; operand_mux_con = MUX_Y; y_con = 1'b1; status_con = 1'b1; end
                        8'h9A: begin alu_op = ALU_PASS; operand_mux_con = MUX_X; stack_pointer_con = 1'b1; end
                        8'hBA: begin alu_op = ALU_PASS; operand_mux_con = MUX_SP; x_con = 1'b1; end
                        8'h18, 8'h38: begin status_con = 1'b1; end
                        default: ;
                     endcase
                  end
                  default: ;
               endcase
            end
            T2: begin
               case (op_class)
                  CLS_IMM: begin
                     operand_mux_con = MUX_DATA;
                     status_con      = 1'b1;
                     case (ir)
                        8'h69: begin alu_op = ALU_ADD;  accumulator_con = 1'b1; end
                        8'hE9: begin alu_op = ALU_SUB;  accumulator_con = 1'b1; end
                        8'h29: begin alu_op = ALU_AND;  accumulator_con = 1'b1; end
                        8'h09: begin alu_op = ALU_OR;   accumulator_con = 1'b1; end
                        8'h49: begin alu_op = ALU_EOR;  accumulator_con = 1'b1; end
                        8'hA9: begin alu_op = ALU_PASS; accumulator_con = 1'b1; end
                        8'hA2: begin alu_op = ALU_PASS; x_con = 1'b1; end
                        8'hA0: begin alu_op = ALU_PASS; y_con = 1'b1; end
                        8'hC9, 8'hE0, 8'hC0: begin alu_op = ALU_CMP; end
                        default: ;
                     endcase
                  end
                  CLS_JMP: begin
                     pc_data      = 1'b1;
                     branch_uncon = 1'b1;
                  end
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mos_decoder.sv
// tb_mos_decoder: self-checking bench for mos_decoder. A cycle-count model of
// each instruction (length plus a per-opcode effect table) predicts every
// output after each clk edge; directed scenarios plus a randomized stream are
// compared against it. Define ILLEGAL_OP_HALT_EN here too when building the
// halting variant of the design.

module tb_mos_decoder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       flush = 1'b0;
   logic       normal = 1'b1;
   logic [7:0] instruction = 8'hEA;
   logic       clk_1, clk_2, w_rd, pc_data, increment, lower_byte;
   logic       x_con, y_con, accumulator_con, status_con, stack_pointer_con;
   logic       branch_uncon, branch_con;
   logic [3:0] alu_op;
   logic [2:0] branch_op;
   logic [1:0] operand_mux_con;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic       w_rd;
      logic       pc_data;
      logic       increment;
      logic       lower_byte;
      logic       x_con;
      logic       y_con;
      logic       acc;
      logic       status;
      logic       sp;
      logic       bu;
      logic       bc;
      logic [3:0] alu;
      logic [2:0] bop;
      logic [1:0] mux;
   } ctl_t;

   typedef struct packed {
      logic [2:0]  kind;
      logic [10:0] row;
   } opinfo_t;

   localparam logic [2:0] K_IMPL = 3'd0;
   localparam logic [2:0] K_IMM  = 3'd1;
   localparam logic [2:0] K_BR   = 3'd2;
   localparam logic [2:0] K_JMP  = 3'd3;
   localparam logic [2:0] K_ILL  = 3'd4;

   // model state: phase, position within instruction (0 = fetch), opcode, halted
   bit         m_ph;
   int         m_cyc;
   logic [7:0] m_op;
   bit         m_halt;

   logic [21:0] dut_vec;
   assign dut_vec = {clk_1, clk_2, w_rd, pc_data, increment, lower_byte, x_con, y_con,
                     accumulator_con, status_con, stack_pointer_con, branch_uncon,
                     branch_con, alu_op, branch_op, operand_mux_con};

   mos_decoder dut (
      .clk(clk), .rst(rst), .flush(flush), .normal(normal), .instruction(instruction),
      .clk_1(clk_1), .clk_2(clk_2), .w_rd(w_rd), .pc_data(pc_data), .increment(increment),
      .lower_byte(lower_byte), .x_con(x_con), .y_con(y_con),
      .accumulator_con(accumulator_con), .status_con(status_con),
      .stack_pointer_con(stack_pointer_con), .branch_uncon(branch_uncon),
      .branch_con(branch_con), .alu_op(alu_op), .branch_op(branch_op),
      .operand_mux_con(operand_mux_con)
   );

   always #5 clk = ~clk;

   // Effect table: row = {alu, mux, x, y, acc, status, sp} for the execute cycle
   function automatic opinfo_t lookup(input logic [7:0] op);
      opinfo_t r;
      r.kind = K_ILL;
      r.row  = {4'hF, 2'b00, 5'b00000};
      case (op)
         8'hEA: begin r.kind = K_IMPL; r.row = {4'hF, 2'b00, 5'b00000}; end
         8'hAA: begin r.kind = K_IMPL; r.row = {4'h5, 2'b00, 5'b10000}; end
         8'hA8: begin r.kind = K_IMPL; r.row = {4'h5, 2'b00, 5'b01000}; end
         8'h8A: begin r.kind = K_IMPL; r.row = {4'h5, 2'b01, 5'b00100}; end
         8'h98: begin r.kind = K_IMPL; r.row = {4'h5, 2'b10, 5'b00100}; end
         8'hE8: begin r.kind = K_IMPL; r.row = {4'h6, 2'b01, 5'b10010}; end
         8'hC8: begin r.kind = K_IMPL; r.row = {4'h6, 2'b10, 5'b01010}; end
         8'hCA: begin r.kind = K_IMPL; r.row = {4'h7, 2'b01, 5'b10010}; end
         8'h88: begin r.kind = K_IMPL; r.row = {4'h7, 2'b10, 5'b01010}; end
         8'h9A: begin r.kind = K_IMPL; r.row = {4'h5, 2'b01, 5'b00001}; end
         8'hBA: begin r.kind = K_IMPL; r.row = {4'h5, 2'b11, 5'b10000}; end
         8'h18, 8'h38: begin r.kind = K_IMPL; r.row = {4'hF, 2'b00, 5'b00010}; end
         8'h69: begin r.kind = K_IMM; r.row = {4'h0, 2'b00, 5'b00110}; end
         8'hE9: begin r.kind = K_IMM; r.row = {4'h1, 2'b00, 5'b00110}; end
         8'h29: begin r.kind = K_IMM; r.row = {4'h2, 2'b00, 5'b00110}; end
         8'h09: begin r.kind = K_IMM; r.row = {4'h3, 2'b00, 5'b00110}; end
         8'h49: begin r.kind = K_IMM; r.row = {4'h4, 2'b00, 5'b00110}; end
         8'hA9: begin r.kind = K_IMM; r.row = {4'h5, 2'b00, 5'b00110}; end
         8'hA2: begin r.kind = K_IMM; r.row = {4'h5, 2'b00, 5'b10010}; end
         8'hA0: begin r.kind = K_IMM; r.row = {4'h5, 2'b00, 5'b01010}; end
         8'hC9, 8'hE0, 8'hC0: begin r.kind = K_IMM; r.row = {4'h8, 2'b00, 5'b00010}; end
         8'h4C: r.kind = K_JMP;
         default: if (op[4:0] == 5'h10) r.kind = K_BR;
      endcase
      return r;
   endfunction

   // Expected strobes for cycle number cyc of instruction op
   function automatic ctl_t exp_ctl(input logic [7:0] op, input int cyc);
      ctl_t c;
      opinfo_t info;
      c = '0;
      c.alu = 4'hF;
      info = lookup(op);
      if (cyc == 0) begin
         c.increment = 1'b1;
      end else if (cyc == 1) begin
         case (info.kind)
            K_IMPL: begin
               c.alu = info.row[10:7];
               c.mux = info.row[6:5];
               {c.x_con, c.y_con, c.acc, c.status, c.sp} = info.row[4:0];
            end
            K_IMM: c.increment = 1'b1;
            K_BR:  begin c.increment = 1'b1; c.bc = 1'b1; c.bop = op[7:5]; end
            K_JMP: begin c.increment = 1'b1; c.lower_byte = 1'b1; end
            default: ;
         endcase
      end else if (cyc == 2) begin
         case (info.kind)
            K_IMM: begin
               c.alu = info.row[10:7];
               c.mux = info.row[6:5];
               {c.x_con, c.y_con, c.acc, c.status, c.sp} = info.row[4:0];
            end
            K_JMP: begin c.pc_data = 1'b1; c.bu = 1'b1; end
            default: ;
         endcase
      end
      return c;
   endfunction

   function automatic logic [21:0] exp_now();
      ctl_t c;
      c = '0;
      c.alu = 4'hF;
      if (!rst) return {2'b00, c};
      if (normal && !flush && !m_halt) c = exp_ctl(m_op, m_cyc);
      return {~m_ph, m_ph, c};
   endfunction

   task automatic reset_model();
      m_ph   = 1'b0;
      m_cyc  = 0;
      m_op   = 8'hEA;
      m_halt = 1'b0;
   endtask

   // Advance the model by one clk edge using the inputs seen at that edge
   task automatic model_edge();
      opinfo_t info;
      int len;
      if (!rst) begin
         reset_model();
      end else begin
         if (m_ph) begin
            if (flush && !m_halt) begin
               m_cyc = 0;
               m_op  = 8'hEA;
            end else if (normal && !m_halt) begin
               if (m_cyc == 0) begin
                  m_op  = instruction;
                  m_cyc = 1;
               end else begin
                  info = lookup(m_op);
                  len = (info.kind == K_IMM || info.kind == K_JMP) ? 3 : 2;
                  if (m_cyc + 1 >= len) begin
`ifdef ILLEGAL_OP_HALT_EN
                     if (info.kind == K_ILL) m_halt = 1'b1;
                     else m_cyc = 0;
`else
                     m_cyc = 0;
`endif
                  end else begin
                     m_cyc = m_cyc + 1;
                  end
               end
            end
         end
         m_ph = ~m_ph;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      reset_model();
      #1;
      checks++;
      if (dut_vec !== exp_now()) begin errors++; $display("[TB] FAIL reset_async: got %h expected %h", dut_vec, exp_now()); end
      repeat (3) begin
         tick();
         checks++;
         if (dut_vec !== exp_now()) begin errors++; $display("[TB] FAIL reset_hold: got %h expected %h", dut_vec, exp_now()); end
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({clk_1, clk_2, increment, pc_data, w_rd, accumulator_con, alu_op} !== {5'b10100, 1'b0, 4'hF}) begin
         errors++;
         $display("[TB] FAIL reset_release: got %b expected %b", {clk_1, clk_2, increment, pc_data, w_rd, accumulator_con, alu_op}, {5'b10100, 1'b0, 4'hF});
      end
      repeat (6) begin
         tick();
         checks++;
         if (dut_vec !== exp_now()) begin errors++; $display("[TB] FAIL reset_phase: got %h expected %h", dut_vec, exp_now()); end
      end
   endtask

   task automatic test_nop();
      bit seen = 1'b0;
      instruction = 8'hEA;
      for (int k = 0; k < 12; k++) begin
         tick();
         checks++;
         if (dut_vec !== exp_now()) begin errors++; $display("[TB] FAIL nop_vec: got %h expected %h", dut_vec, exp_now()); end
         if (m_cyc == 1 && m_op == 8'hEA && !seen) begin
            seen = 1'b1;
            checks++;
            if ({increment, x_con, y_con, accumulator_con, status_con, stack_pointer_con, alu_op} !== {6'b0, 4'hF}) begin
               errors++;
               $display("[TB] FAIL nop_t1: got %b expected %b", {increment, x_con, y_con, accumulator_con, status_con, stack_pointer_con, alu_op}, {6'b0, 4'hF});
            end
         end
      end
      checks++;
      if (!seen) begin errors++; $display("[TB] FAIL nop_reach: got 0 expected 1"); end
   endtask

   task automatic test_adc();
      bit seen1 = 1'b0;
      bit seen2 = 1'b0;
      instruction = 8'h69;
      for (int k = 0; k < 30 && !seen2; k++) begin
         tick();
         checks++;
         if (dut_vec !== exp_now()) begin errors++; $display("[TB] FAIL adc_vec: got %h expected %h", dut_vec, exp_now()); end
         if (m_op == 8'h69 && m_cyc == 1 && !seen1) begin
            seen1 = 1'b1;
            checks++;
            if ({increment, accumulator_con} !== 2'b10) begin errors++; $display("[TB] FAIL adc_t1: got %b expected 10", {increment, accumulator_con}); end
         end
         if (m_op == 8'h69 && m_cyc == 2) begin
            seen2 = 1'b1;
            checks++;
            if ({alu_op, operand_mux_con, accumulator_con, status_con} !== {4'h0, 2'b00, 2'b11}) begin
               errors++;
               $display("[TB] FAIL adc_t2: got %b expected %b", {alu_op, operand_mux_con, accumulator_con, status_con}, {4'h0, 2'b00, 2'b11});
            end
         end
      end
      checks++;
      if (!(seen1 && seen2)) begin errors++; $display("[TB] FAIL adc_reach: got %b expected 11", {seen1, seen2}); end
   endtask

   task automatic test_branch();
      bit seen = 1'b0;
      instruction = 8'hF0;
      for (int k = 0; k < 30; k++) begin
         tick();
         checks++;
         if (dut_vec !== exp_now()) begin errors++; $display("[TB] FAIL branch_vec: got %h expected %h", dut_vec, exp_now()); end
         if (m_op == 8'hF0 && m_cyc == 1 && !seen) begin
            seen = 1'b1;
            checks++;
            if ({branch_con, branch_op, increment} !== 5'b1_111_1) begin
               errors++;
               $display("[TB] FAIL branch_t1: got %b expected 11111", {branch_con, branch_op, increment});
            end
         end
      end
      checks++;
      if (!seen) begin errors++; $display("[TB] FAIL branch_reach: got 0 expected 1"); end
   endtask

   task automatic test_jmp();
      bit seen1 = 1'b0;
      bit seen2 = 1'b0;
      instruction = 8'h4C;
      for (int k = 0; k < 30 && !seen2; k++) begin
         tick();
         checks++;
         if (dut_vec !== exp_now()) begin errors++; $display("[TB] FAIL jmp_vec: got %h expected %h", dut_vec, exp_now()); end
         if (m_op == 8'h4C && m_cyc == 1 && !seen1) begin
            seen1 = 1'b1;
            checks++;
            if ({lower_byte, increment, branch_uncon} !== 3'b110) begin errors++; $display("[TB] FAIL jmp_t1: got %b expected 110", {lower_byte, increment, branch_uncon}); end
         end
         if (m_op == 8'h4C && m_cyc == 2) begin
            seen2 = 1'b1;
            checks++;
            if ({branch_uncon, pc_data, lower_byte} !== 3'b110) begin errors++; $display("[TB] FAIL jmp_t2: got %b expected 110", {branch_uncon, pc_data, lower_byte}); end
         end
      end
      checks++;
      if (!(seen1 && seen2)) begin errors++; $display("[TB] FAIL jmp_reach: got %b expected 11", {seen1, seen2}); end
   endtask

   task automatic test_implied();
      logic [7:0] ops [13] = '{8'hAA, 8'hA8, 8'h8A, 8'h98, 8'hE8, 8'hC8, 8'hCA,
                               8'h88, 8'h9A, 8'hBA, 8'h18, 8'h38, 8'hA2};
      for (int i = 0; i < 13; i++) begin
         instruction = ops[i];
         repeat (6) begin
            tick();
            checks++;
            if (dut_vec !== exp_now()) begin errors++; $display("[TB] FAIL implied_%h: got %h expected %h", ops[i], dut_vec, exp_now()); end
         end
      end
   endtask

   task automatic test_flush();
      bit seen = 1'b0;
      instruction = 8'h69;
      for (int k = 0; k < 30 && !seen; k++) begin
         tick();
         checks++;
         if (dut_vec !== exp_now()) begin errors++; $display("[TB] FAIL flush_pre: got %h expected %h", dut_vec, exp_now()); end
         if (m_op == 8'h69 && m_cyc == 1) seen = 1'b1;
      end
      checks++;
      if (!seen) begin errors++; $display("[TB] FAIL flush_reach: got 0 expected 1"); end
      flush = 1'b1;
      instruction = 8'hEA;
      #1;
      repeat (2) begin
         checks++;
         if (dut_vec !== exp_now() || accumulator_con !== 1'b0) begin errors++; $display("[TB] FAIL flush_gate: got %h expected %h", dut_vec, exp_now()); end
         tick();
      end
      flush = 1'b0;
      #1;
      checks++;
      if ({increment, accumulator_con, status_con} !== 3'b100) begin errors++; $display("[TB] FAIL flush_fetch: got %b expected 100", {increment, accumulator_con, status_con}); end
      repeat (8) begin
         tick();
         checks++;
         if (dut_vec !== exp_now() || accumulator_con !== 1'b0) begin errors++; $display("[TB] FAIL flush_post: got %h expected %h", dut_vec, exp_now()); end
      end
   endtask

   task automatic test_stall();
      bit seen = 1'b0;
      instruction = 8'h69;
      for (int k = 0; k < 30 && !seen; k++) begin
         tick();
         checks++;
         if (dut_vec !== exp_now()) begin errors++; $display("[TB] FAIL stall_pre: got %h expected %h", dut_vec, exp_now()); end
         if (m_op == 8'h69 && m_cyc == 1) seen = 1'b1;
      end
      checks++;
      if (!seen) begin errors++; $display("[TB] FAIL stall_reach: got 0 expected 1"); end
      normal = 1'b0;
      instruction = 8'hEA;
      repeat (5) begin
         tick();
         checks++;
         if (dut_vec !== exp_now() || increment !== 1'b0) begin errors++; $display("[TB] FAIL stall_hold: got %h expected %h", dut_vec, exp_now()); end
      end
      normal = 1'b1;
      #1;
      checks++;
      if ({increment, accumulator_con} !== 2'b10) begin errors++; $display("[TB] FAIL stall_resume: got %b expected 10", {increment, accumulator_con}); end
      repeat (6) begin
         tick();
         checks++;
         if (dut_vec !== exp_now()) begin errors++; $display("[TB] FAIL stall_post: got %h expected %h", dut_vec, exp_now()); end
      end
   endtask

   task automatic test_illegal();
      instruction = 8'h02;
      repeat (10) begin
         tick();
         checks++;
         if (dut_vec !== exp_now()) begin errors++; $display("[TB] FAIL illegal_vec: got %h expected %h", dut_vec, exp_now()); end
      end
      flush = 1'b1;
      repeat (2) begin
         tick();
         checks++;
         if (dut_vec !== exp_now()) begin errors++; $display("[TB] FAIL illegal_flush: got %h expected %h", dut_vec, exp_now()); end
      end
      flush = 1'b0;
      instruction = 8'hEA;
      repeat (6) begin
         tick();
         checks++;
         if (dut_vec !== exp_now()) begin errors++; $display("[TB] FAIL illegal_after: got %h expected %h", dut_vec, exp_now()); end
      end
      if (m_halt) begin
         rst = 1'b0;
         reset_model();
         tick();
         checks++;
         if (dut_vec !== exp_now()) begin errors++; $display("[TB] FAIL illegal_reset: got %h expected %h", dut_vec, exp_now()); end
         rst = 1'b1;
      end
   endtask

   task automatic test_random();
      logic [7:0] pool [33] = '{8'hEA, 8'hAA, 8'hA8, 8'h8A, 8'h98, 8'hE8, 8'hC8, 8'hCA, 8'h88,
                                8'h9A, 8'hBA, 8'h18, 8'h38, 8'h69, 8'hE9, 8'h29, 8'h09, 8'h49,
                                8'hA9, 8'hA2, 8'hA0, 8'hC9, 8'hE0, 8'hC0, 8'h10, 8'h30, 8'h50,
                                8'h70, 8'h90, 8'hB0, 8'hD0, 8'hF0, 8'h4C};
      for (int k = 0; k < 600; k++) begin
         instruction = ($urandom_range(0, 4) == 0) ? 8'($urandom) : pool[$urandom_range(0, 32)];
         normal = ($urandom_range(0, 9) != 0);
         flush  = ($urandom_range(0, 19) == 0);
         if (m_halt && $urandom_range(0, 3) == 0) begin
            rst = 1'b0;
            reset_model();
            #1;
            checks++;
            if (dut_vec !== exp_now()) begin errors++; $display("[TB] FAIL random_rst: got %h expected %h", dut_vec, exp_now()); end
            tick();
            rst = 1'b1;
         end
         tick();
         checks++;
         if (dut_vec !== exp_now()) begin errors++; $display("[TB] FAIL random_vec: op %h cyc %0d got %h expected %h", m_op, m_cyc, dut_vec, exp_now()); end
      end
      flush = 1'b0;
      normal = 1'b1;
   endtask

   // Run every scenario in order and report the totals
   initial begin
      test_reset();
      test_nop();
      test_adc();
      test_branch();
      test_jmp();
      test_implied();
      test_flush();
      test_stall();
      test_illegal();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Upper bound on run time in case a scenario never completes
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
